// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_ctrl
// Description : Program-counter sequencing controller. It drives the PC
//               register's enable and next value, issues instruction fetches,
//               arbitrates exception/jump/branch redirects, holds a single
//               pending redirect across wait/stall cycles, and substitutes the
//               exception vector for misaligned targets.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0040_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic        pc_ena,
    output logic [31:0] pc_next,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        br_take,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        exc,
    input  logic        halt,
    output logic        instr_valid,
    output logic        misalign,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    // Redirect priority levels; a larger value wins.
    localparam logic [1:0] c_PRIO_NONE = 2'd0;
    localparam logic [1:0] c_PRIO_BR   = 2'd1;
    localparam logic [1:0] c_PRIO_JMP  = 2'd2;
    localparam logic [1:0] c_PRIO_EXC  = 2'd3;

    localparam logic [31:0] c_PC_STEP = 32'd4;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        r_pend_valid;
    logic [1:0]  r_pend_prio;
    logic [31:0] r_pend_target;

    logic        w_in_fetch;
    logic        w_accept;
    logic [1:0]  w_live_prio;
    logic [31:0] w_live_target;
    logic [31:0] w_seq_pc;
    logic [31:0] w_sel_target;
    logic        w_sel_misalign;
    logic [31:0] w_fetch_pc;
    logic        w_pend_load;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    assign w_in_fetch = (r_state == S_FETCH);

    // A fetch completes only when the pipeline is not stalled; ack during a
    // stall is deliberately ignored.
    assign w_accept   = w_in_fetch && !stall && imem_ack;

    // 32-bit addition wraps naturally from 32'hFFFF_FFFC to 32'h0000_0000.
    assign w_seq_pc   = pc_cur + c_PC_STEP;

    // Arbitrate the redirects presented in this cycle: exc > jmp > br_take.
    always_comb begin
        w_live_prio   = c_PRIO_NONE;
        w_live_target = w_seq_pc;
        if (exc) begin
            w_live_prio   = c_PRIO_EXC;
            w_live_target = EXC_VEC;
        end else if (jmp) begin
            w_live_prio   = c_PRIO_JMP;
            w_live_target = jmp_target;
        end else if (br_take) begin
            w_live_prio   = c_PRIO_BR;
            w_live_target = br_target;
        end
    end

    // Pick the PC to load: live redirect, then pending redirect, then pc+4.
    always_comb begin
        w_sel_target = w_seq_pc;
        if (w_live_prio != c_PRIO_NONE) begin
            w_sel_target = w_live_target;
        end else if (r_pend_valid) begin
            w_sel_target = r_pend_target;
        end
    end

    // A target that is not word aligned is replaced by the exception vector.
    assign w_sel_misalign = (w_sel_target[1:0] != 2'b00);
    assign w_fetch_pc     = w_sel_misalign ? EXC_VEC : w_sel_target;

    // A redirect seen while fetching but not accepting is remembered; a newer
    // one only displaces it when it is at least as important.
    assign w_pend_load = w_in_fetch && !w_accept &&
                         (w_live_prio != c_PRIO_NONE) &&
                         (!r_pend_valid || (w_live_prio >= r_pend_prio));

    // ------------------------------------------------------------------------
    // Pending redirect register: cleared on reset and whenever consumed.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid  <= 1'b0;
            r_pend_prio   <= c_PRIO_NONE;
            r_pend_target <= 32'h0000_0000;
        end else if (w_accept) begin
            r_pend_valid  <= 1'b0;
            r_pend_prio   <= c_PRIO_NONE;
            r_pend_target <= 32'h0000_0000;
        end else if (w_pend_load) begin
            r_pend_valid  <= 1'b1;
            r_pend_prio   <= w_live_prio;
            r_pend_target <= w_live_target;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic. A halt alongside an accepted fetch still lets
    // that PC update happen this cycle, since the outputs are independent.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = halt ? S_HALT : S_FETCH;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // FSM: output logic. Everything is held quiet while reset is asserted.
    always_comb begin
        pc_ena      = 1'b0;
        pc_next     = w_fetch_pc;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        misalign    = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            case (r_state)
                S_BOOT: begin
                    pc_ena  = 1'b1;
                    pc_next = RESET_VEC;
                end
                S_FETCH: begin
                    busy        = 1'b1;
                    imem_req    = !stall;
                    pc_ena      = w_accept;
                    instr_valid = w_accept;
                    misalign    = w_accept && w_sel_misalign;
                end
                default: begin
                    pc_ena = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_seq_ctrl
// Description : Directed-vector bench for pc_seq_ctrl. The driver pushes
//               hand-computed expectations into queues; a monitor on the
//               falling edge pops and compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        pc_ena;
    logic [31:0] pc_next;
    logic        imem_req;
    logic        imem_ack;
    logic        stall;
    logic        br_take;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc;
    logic        halt;
    logic        instr_valid;
    logic        misalign;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Per-cycle control expectation {pc_ena, imem_req, instr_valid, misalign, busy}
    logic [4:0]  q_ctl[$];
    // Expected pc_next for every cycle where pc_ena is expected high
    logic [31:0] q_txn[$];

    localparam logic [4:0] QUIET = 5'b00000;
    localparam logic [4:0] BOOTC = 5'b10000;
    localparam logic [4:0] WAITC = 5'b01001;
    localparam logic [4:0] STALC = 5'b00001;
    localparam logic [4:0] ACC   = 5'b11101;
    localparam logic [4:0] ACCM  = 5'b11111;

    always #5 clk = ~clk;

    pc_seq_ctrl #(
        .RESET_VEC (32'h0040_0000),
        .EXC_VEC   (32'h0040_0004)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_cur),
        .pc_ena      (pc_ena),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .br_take     (br_take),
        .br_target   (br_target),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .exc         (exc),
        .halt        (halt),
        .instr_valid (instr_valid),
        .misalign    (misalign),
        .busy        (busy)
    );

    // Apply one cycle of stimulus just after the rising edge and queue its
    // expected response.
    task automatic vec(input logic r, input logic s, input logic a,
                       input logic [31:0] pc,
                       input logic e, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt, input logic h,
                       input logic [4:0] ctl, input logic [31:0] nxt);
        @(posedge clk);
        #1;
        rst        = r;
        stall      = s;
        imem_ack   = a;
        pc_cur     = pc;
        exc        = e;
        jmp        = j;
        jmp_target = jt;
        br_take    = b;
        br_target  = bt;
        halt       = h;
        q_ctl.push_back(ctl);
        if (ctl[4]) q_txn.push_back(nxt);
    endtask

    // Monitor: compare outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [4:0]  exp_ctl;
        logic [4:0]  act_ctl;
        logic [31:0] exp_pc;
        if (q_ctl.size() > 0) begin
            exp_ctl = q_ctl.pop_front();
            act_ctl = {pc_ena, imem_req, instr_valid, misalign, busy};
            checks++;
            if (act_ctl !== exp_ctl) begin
                errors++;
                $display("FAIL ctl t=%0t ena/req/iv/mis/busy got %b want %b",
                         $time, act_ctl, exp_ctl);
            end
        end
        if (pc_ena === 1'b1) begin
            checks++;
            if (q_txn.size() == 0) begin
                errors++;
                $display("FAIL pc_next t=%0t unexpected pc_ena with pc_next %h, none expected",
                         $time, pc_next);
            end else begin
                exp_pc = q_txn.pop_front();
                if (pc_next !== exp_pc) begin
                    errors++;
                    $display("FAIL pc_next t=%0t got %h want %h", $time, pc_next, exp_pc);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        imem_ack   = 1'b0;
        pc_cur     = 32'h0;
        exc        = 1'b0;
        jmp        = 1'b0;
        jmp_target = 32'h0;
        br_take    = 1'b0;
        br_target  = 32'h0;
        halt       = 1'b0;

        //   rst stl ack pc             exc jmp jt             br  bt             hlt exp    pc_next
        // Reset for two cycles, then BOOT loads RESET_VEC
        vec(1, 0, 0, 32'h0000_0000, 0, 0, 32'h0,          0, 32'h0,          0, QUIET, 32'h0);
        vec(1, 0, 0, 32'h0000_0000, 0, 0, 32'h0,          0, 32'h0,          0, QUIET, 32'h0);
        vec(0, 0, 0, 32'h0000_0000, 0, 0, 32'h0,          0, 32'h0,          0, BOOTC, 32'h0040_0000);
        // Sequential fetch with ack every cycle, then wrap
        vec(0, 0, 1, 32'h0040_0000, 0, 0, 32'h0,          0, 32'h0,          0, ACC,   32'h0040_0004);
        vec(0, 0, 1, 32'h0040_0004, 0, 0, 32'h0,          0, 32'h0,          0, ACC,   32'h0040_0008);
        vec(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,          0, 32'h0,          0, ACC,   32'h0000_0000);
        // Jump while waiting for ack is held pending, consumed two cycles later
        vec(0, 0, 0, 32'h0040_0008, 0, 1, 32'h0040_0100, 0, 32'h0,          0, WAITC, 32'h0);
        vec(0, 0, 0, 32'h0040_0008, 0, 0, 32'h0,          0, 32'h0,          0, WAITC, 32'h0);
        vec(0, 0, 1, 32'h0040_0008, 0, 0, 32'h0,          0, 32'h0,          0, ACC,   32'h0040_0100);
        vec(0, 0, 1, 32'h0040_0100, 0, 0, 32'h0,          0, 32'h0,          0, ACC,   32'h0040_0104);
        // All redirects together: exception wins
        vec(0, 0, 1, 32'h0040_0104, 1, 1, 32'h0040_0200, 1, 32'h0040_0300, 0, ACC,   32'h0040_0004);
        // Misaligned branch target becomes EXC_VEC with misalign pulse
        vec(0, 0, 1, 32'h0040_0004, 0, 0, 32'h0,          1, 32'h0040_0102, 0, ACCM,  32'h0040_0004);
        // Stall with ack: no request, no update
        vec(0, 1, 1, 32'h0040_0004, 0, 0, 32'h0,          0, 32'h0,          0, STALC, 32'h0);
        // Pending jump is not displaced by a later lower-priority branch
        vec(0, 1, 0, 32'h0040_0004, 0, 1, 32'h0040_0200, 0, 32'h0,          0, STALC, 32'h0);
        vec(0, 0, 0, 32'h0040_0004, 0, 0, 32'h0,          1, 32'h0040_0300, 0, WAITC, 32'h0);
        vec(0, 0, 1, 32'h0040_0010, 0, 0, 32'h0,          0, 32'h0,          0, ACC,   32'h0040_0200);
        vec(0, 0, 1, 32'h0040_0200, 0, 0, 32'h0,          0, 32'h0,          0, ACC,   32'h0040_0204);
        // Equal-priority redirect replaces the pending one
        vec(0, 0, 0, 32'h0040_0204, 0, 0, 32'h0,          1, 32'h0040_0300, 0, WAITC, 32'h0);
        vec(0, 0, 0, 32'h0040_0204, 0, 0, 32'h0,          1, 32'h0040_0400, 0, WAITC, 32'h0);
        vec(0, 0, 1, 32'h0040_0204, 0, 0, 32'h0,          0, 32'h0,          0, ACC,   32'h0040_0400);
        // Halt with ack completes the update, then everything goes quiet
        vec(0, 0, 1, 32'h0040_0400, 0, 0, 32'h0,          0, 32'h0,          1, ACC,   32'h0040_0404);
        vec(0, 0, 1, 32'h0040_0404, 1, 1, 32'h0040_0500, 0, 32'h0,          0, QUIET, 32'h0);
        vec(0, 0, 1, 32'h0040_0404, 0, 0, 32'h0,          1, 32'h0040_0600, 1, QUIET, 32'h0);
        // Reset from HALT, late ack during BOOT is ignored
        vec(1, 0, 1, 32'h0040_0404, 0, 0, 32'h0,          0, 32'h0,          0, QUIET, 32'h0);
        vec(0, 0, 1, 32'h0040_0404, 0, 0, 32'h0,          0, 32'h0,          0, BOOTC, 32'h0040_0000);
        // Reset mid-fetch overrides ack, halt and redirects
        vec(0, 0, 0, 32'h0040_0000, 0, 0, 32'h0,          0, 32'h0,          0, WAITC, 32'h0);
        vec(1, 1, 1, 32'h0040_0000, 1, 1, 32'h0040_0700, 1, 32'h0040_0800, 1, QUIET, 32'h0);
        vec(0, 0, 1, 32'h0040_0000, 0, 0, 32'h0,          0, 32'h0,          0, BOOTC, 32'h0040_0000);
        // Pending state was cleared by reset: plain sequential step
        vec(0, 0, 1, 32'h0040_0000, 0, 0, 32'h0,          0, 32'h0,          0, ACC,   32'h0040_0004);

        // Trailing idle cycle under reset, then confirm every expectation was consumed
        @(posedge clk);
        #1;
        rst      = 1'b1;
        imem_ack = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (q_ctl.size() != 0 || q_txn.size() != 0) begin
            errors++;
            $display("FAIL drain leftover ctl=%0d txn=%0d want 0 and 0",
                     q_ctl.size(), q_txn.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'h0040_0000, PC value loaded on leaving reset.
REQ-002 Parameter EXC_VEC, default 32'h0040_0004, PC value loaded on exception or misaligned target.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc_cur  input  32  current PC, driven by the PC register's data_out.
REQ-006 pc_ena  output  1  write enable to the PC register's ena.
REQ-007 pc_next  output  32  next PC to the PC register's data_in.
REQ-008 imem_req  output  1  fetch request to instruction memory for address pc_cur.
REQ-009 imem_ack  input  1  fetch complete for the current request.
REQ-010 stall  input  1  pipeline stall, suspends fetch.
REQ-011 br_take, br_target  input  1, 32  conditional branch redirect, pulse.
REQ-012 jmp, jmp_target  input  1, 32  unconditional jump redirect, pulse.
REQ-013 exc  input  1  exception redirect to EXC_VEC, pulse.
REQ-014 halt  input  1  stop fetching until reset.
REQ-015 instr_valid  output  1  one-cycle pulse, fetched word at pc_cur accepted.
REQ-016 misalign  output  1  one-cycle pulse, redirect target had [1:0] != 0.
REQ-017 busy  output  1  high in FETCH state.

Function
REQ-018 FSM states SHALL be BOOT, FETCH, HALT; encoding is free.
REQ-019 BOOT: pc_ena=1, pc_next=RESET_VEC for exactly one cycle, then FETCH.
REQ-020 FETCH with stall=0: imem_req=1 combinationally.
REQ-021 FETCH with stall=1: imem_req=0, pc_ena=0, imem_ack ignored.
REQ-022 FETCH, stall=0, imem_ack=0: pc_ena=0, instr_valid=0, state held.
REQ-023 FETCH, stall=0, imem_ack=1: pc_ena=1, instr_valid=1, pc_next = selected PC in the same cycle.
REQ-024 Selection priority: exc > jmp > br_take > pending redirect > pc_cur+4.
REQ-025 A redirect asserted while not accepting (ack=0 or stall=1) SHALL be latched into a pending register; a later redirect replaces it only if of equal or higher priority.
REQ-026 Pending register SHALL clear on the cycle it is consumed (pc_ena=1).
REQ-027 pc_cur+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-028 Selected target with [1:0] != 0 SHALL be replaced by EXC_VEC and misalign pulsed on the cycle pc_ena=1.
REQ-029 halt=1 in any non-BOOT state: next state HALT; halt in same cycle as ack still completes that update first.
REQ-030 HALT: pc_ena=0, imem_req=0, all redirects ignored; exit only via rst.
REQ-031 busy=1 only in FETCH.

Reset
REQ-032 While rst=1 at a rising edge: state<=BOOT, pending cleared; pc_ena, imem_req, instr_valid, misalign, busy all 0 during reset cycles.
REQ-033 rst mid-fetch SHALL abandon the outstanding request; a late imem_ack after reset SHALL be ignored.
REQ-034 rst SHALL override halt, stall and all redirects.

Verification
REQ-035 rst 2 cycles then release -> BOOT cycle pc_ena=1, pc_next=32'h0040_0000; next cycle imem_req=1.
REQ-036 pc_cur=32'h0040_0000, ack every cycle -> pc_next 32'h0040_0004, then 32'h0040_0008, instr_valid each cycle.
REQ-037 pc_cur=32'hFFFF_FFFC, ack=1 -> pc_next=32'h0000_0000.
REQ-038 jmp=1 target 32'h0040_0100 while ack=0, ack two cycles later -> pc_next=32'h0040_0100, then sequential.
REQ-039 exc, jmp, br_take same cycle with ack=1 -> pc_next=32'h0040_0004; br_target=32'h0040_0102 alone -> pc_next=32'h0040_0004, misalign=1.
REQ-040 stall=1 with ack=1 -> pc_ena=0, imem_req=0; halt=1 -> outputs quiet until rst, then BOOT sequence repeats.
